mul_unit_pipelined: RTL
=======================

# mul_unit_pipelined

Parametrised successor to the fixed two-stage integer multiplier execution unit. It executes RV32M MUL/MULH/MULHSU/MULHU with a configurable pipeline depth (LATENCY) and ID width, and uses a per-stage valid/stall pipeline driven by the writeback acknowledge. It sits between issue and the writeback arbiter in the core's execution-unit set, and exposes the same issue/writeback handshake as the other units.

## Interface
- LATENCY, 2: cycles from accepted request to wb_done with no backpressure; legal range 2..4.
- ID_WIDTH, 3: width of the instruction ID carried through the pipeline.
- clk  input  1  clock. Single clock domain; all logic is on the rising edge.
- rst  input  1  reset. Synchronous and active-high.
- issue_new_request  input  1  request valid. Only meaningful when issue_ready=1.
- issue_fn3  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU. fn3[2]=1 is never issued to this unit.
- issue_rs1  input  32  operand A.
- issue_rs2  input  32  operand B.
- issue_id  input  ID_WIDTH  instruction ID.
- issue_ready  output  1  unit can accept a request this cycle.
- wb_ack  input  1  writeback consumes the current output this cycle.
- wb_done  output  1  result valid.
- wb_id  output  ID_WIDTH  ID of the result.
- wb_rd  output  32  result data.
- perf_issued  output  32  present only with MUL_UNIT_PERF_EN; see Configuration.
- perf_stall  output  32  present only with MUL_UNIT_PERF_EN; see Configuration.

## Operation
- The pipeline has LATENCY stages, S0..S(LATENCY-1). Each stage holds a valid bit, the ID, and a high-word flag.
- S0 captures the 33-bit sign/zero-extended operands:
  - rs1 is signed for MULH and MULHSU.
  - rs2 is signed for MULH only.
  - high flag = (fn3 != 000).
- The 66-bit signed product of the S0 operands is formed and registered in S1. Stages S2 onward carry the product register forward, which allows retiming.
- Output: wb_rd = high ? product[63:32] : product[31:0], taken from S(LATENCY-1). wb_done = valid[LATENCY-1]. wb_id = id[LATENCY-1].
- Advance rules:
  - adv[LATENCY-1] = ~valid[LATENCY-1] | wb_ack.
  - adv[i] = ~valid[i] | adv[i+1].
  - issue_ready = adv[0], combinational.
- A stage with adv=1 loads the contents of the previous stage. S0 loads issue_new_request together with its operands.
- A stage that does not advance holds all of its fields.
- Bubbles collapse: a stalled output stage does not block earlier stages that are invalid.
- wb_ack while wb_done=0 is ignored.
- Simultaneous wb_ack and new request with the pipeline full: both occur in the same cycle, so throughput is 1 per cycle.
- Reset clears all valid bits. Product, operand, ID and flag registers reset to 0. Reset asserted mid-operation discards all in-flight results; none is reported after reset.

## Timing
- Reset values: wb_done=0, wb_id=0, wb_rd=0, issue_ready=1 (all stages invalid), perf counters=0.
- Latency: a request accepted at edge t gives wb_done=1 in the cycle after edge t+LATENCY-1. A back-to-back stream with wb_ack held at 1 gives one result per cycle.
- Backpressure: with wb_ack=0 and all stages valid, issue_ready=0 in the same cycle.
- issue_ready depends combinationally on wb_ack. There is no combinational path from any issue input to any wb_* output.
- wb_rd and wb_id hold stable while wb_done=1 and wb_ack=0.

## Configuration
- MUL_UNIT_PERF_EN defined:
  - perf_issued increments on each accepted request (issue_new_request & issue_ready).
  - perf_stall increments on each cycle with wb_done & ~wb_ack.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and clear on rst.
- MUL_UNIT_PERF_EN undefined: the counters and both ports are absent. Datapath behaviour is identical.

## Test plan
- LATENCY=2, MUL rs1=7, rs2=0xFFFFFFFD (-3), wb_ack=1 -> wb_done 2 cycles later, wb_rd=0xFFFFFFEB, wb_id equals issued ID.
- High-word variants, LATENCY=3:
  - MULH 0x80000000*0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF.
- LATENCY=4, issue 6 back-to-back with IDs 0..5 and wb_ack=0 -> issue_ready drops after 4 accepts. Then toggle wb_ack 1,0,1,... -> results emerge in ID order 0..5, none lost or duplicated, wb_rd stable during stalls.
- Bubble collapse: issue, idle 1 cycle, issue, with wb_ack=0 -> second op advances until it sits behind the first; issue_ready stays 1 until all stages are full.
- Reset mid-stream: 3 ops in flight, rst for 1 cycle -> wb_done=0 and issue_ready=1 the next cycle; subsequent MUL 3*5 returns 15 with no stale results.
- MUL_UNIT_PERF_EN: 10 accepts and 4 stall cycles -> perf_issued=10, perf_stall=4. Preload 0xFFFFFFFF through a force, one accept -> perf_issued=0.

Source files
------------

// File: rtl/mul_unit_pipelined.sv
// mul_unit_pipelined: RV32M MUL/MULH/MULHSU/MULHU execution unit with a
// LATENCY-deep (2..4) valid/stall pipeline. Each stage advances when it is
// empty or when the stage after it advances. Bubbles therefore collapse
// behind a stalled output. The output stage is released by wb_ack.
// Optional feature macro: MUL_UNIT_PERF_EN adds the perf_issued and
// perf_stall counters and their ports.
module mul_unit_pipelined #(
    parameter int LATENCY  = 2,
    parameter int ID_WIDTH = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_new_request,
    input  logic [2:0]          issue_fn3,
    input  logic [31:0]         issue_rs1,
    input  logic [31:0]         issue_rs2,
    input  logic [ID_WIDTH-1:0] issue_id,
    output logic                issue_ready,
    input  logic                wb_ack,
    output logic                wb_done,
    output logic [ID_WIDTH-1:0] wb_id,
    output logic [31:0]         wb_rd
`ifdef MUL_UNIT_PERF_EN
    ,
    output logic [31:0]         perf_issued,
    output logic [31:0]         perf_stall
`endif
);

    // per-stage control: valid, ID and high-word select
    logic [LATENCY-1:0]               vld_pipe;
    logic [LATENCY-1:0]               adv;
    logic [LATENCY-1:0][ID_WIDTH-1:0] id_pipe;
    logic [LATENCY-1:0]               hi_pipe;

    // S0 operands (33-bit sign/zero extended); S1.. carry the product
    logic [32:0]                      s0_a;
    logic [32:0]                      s0_b;
    logic [LATENCY-1:1][63:0]         prod_pipe;
    logic [63:0]                      s0_prod;
    logic                             adv_chain;

    logic                             rs1_signed;
    logic                             rs2_signed;

    assign rs1_signed = (issue_fn3 == 3'b001) || (issue_fn3 == 3'b010);
    assign rs2_signed = (issue_fn3 == 3'b001);

    // Only the low 64 bits of the 66-bit signed product are ever selected,
    // so the multiply is done modulo 2^64 on sign-extended operands.
    assign s0_prod = {{31{s0_a[32]}}, s0_a} * {{31{s0_b[32]}}, s0_b};

    // advance chain from the output stage back to S0
    always_comb begin
        adv_chain          = ~vld_pipe[LATENCY-1] | wb_ack;
        adv                = '0;
        adv[LATENCY-1]     = adv_chain;
        for (int i = LATENCY - 2; i >= 0; i--) begin
            adv_chain = ~vld_pipe[i] | adv_chain;
            adv[i]    = adv_chain;
        end
    end

    assign issue_ready = adv[0];

    // stage registers: load from the previous stage on advance, else hold
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            id_pipe   <= '0;
            hi_pipe   <= '0;
            s0_a      <= '0;
            s0_b      <= '0;
            prod_pipe <= '0;
        end else begin
            if (adv[0]) begin
                vld_pipe[0] <= issue_new_request;
                id_pipe[0]  <= issue_id;
                hi_pipe[0]  <= (issue_fn3 != 3'b000);
                s0_a        <= {rs1_signed & issue_rs1[31], issue_rs1};
                s0_b        <= {rs2_signed & issue_rs2[31], issue_rs2};
            end
            for (int i = 1; i < LATENCY; i++) begin
                if (adv[i]) begin
                    vld_pipe[i] <= vld_pipe[i-1];
                    id_pipe[i]  <= id_pipe[i-1];
                    hi_pipe[i]  <= hi_pipe[i-1];
                end
            end
            if (adv[1]) begin
                prod_pipe[1] <= s0_prod;
            end
            for (int i = 2; i < LATENCY; i++) begin
                if (adv[i]) begin
                    prod_pipe[i] <= prod_pipe[i-1];
                end
            end
        end
    end

    assign wb_done = vld_pipe[LATENCY-1];
    assign wb_id   = id_pipe[LATENCY-1];
    assign wb_rd   = hi_pipe[LATENCY-1] ? prod_pipe[LATENCY-1][63:32]
                                        : prod_pipe[LATENCY-1][31:0];

`ifdef MUL_UNIT_PERF_EN
    logic [31:0] perf_issued_r;
    logic [31:0] perf_stall_r;

    // accepted-request and output-stall counters, free-running with wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_issued_r <= '0;
            perf_stall_r  <= '0;
        end else begin
            if (issue_new_request & issue_ready) begin
                perf_issued_r <= perf_issued_r + 32'd1;
            end
            if (wb_done & ~wb_ack) begin
                perf_stall_r <= perf_stall_r + 32'd1;
            end
        end
    end

    assign perf_issued = perf_issued_r;
    assign perf_stall  = perf_stall_r;
`endif

endmodule
